// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants and key-code mapping for the keypad scanner.
package keypad_pkg;
  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam int NCOL = 3;
  function automatic logic [3:0] key_code(input logic [2:0] r, input logic [1:0] c);
    return 4'(r) * 4'd3 + 4'(c);
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: pass-level filter that accepts a candidate after DEBOUNCE identical passes.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       pass_done,
  input  logic [3:0] candidate,
  output logic [3:0] keycode,
  output logic       press,
  output logic       press_valid
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  typedef enum logic {IDLE, HELD} state_t;
  state_t state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] prev_q, key_q;
  logic pv_q, accept;
  always_comb begin
    cnt_d = (candidate != prev_q) ? CW'(1) : (cnt_q == CW'(DEBOUNCE)) ? cnt_q : cnt_q + 1'b1;
    accept = pass_done && cnt_d == CW'(DEBOUNCE);
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prev_q  <= KEY_NONE;
      key_q   <= 4'd0;
      pv_q    <= 1'b0;
    end else begin
      pv_q <= 1'b0;
      if (pass_done) begin
        prev_q <= candidate;
        cnt_q  <= cnt_d;
      end
      // A held key is re-accepted every stable pass; only a new code pulses.
      if (accept && candidate == KEY_NONE)
        state_q <= IDLE;
      else if (accept && (state_q == IDLE || candidate != key_q)) begin
        state_q <= HELD;
        key_q   <= candidate;
        pv_q    <= 1'b1;
      end
    end
  end
  assign keycode     = key_q;
  assign press       = state_q == HELD;
  assign press_valid = pv_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: row-scanning keypad driver with column synchroniser and pass accumulator.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROWS     = 4,
  parameter int DWELL    = 4,
  parameter int DEBOUNCE = 4
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic [NCOL-1:0] column,
  output logic [2:0]      sel,
  output logic [3:0]      scancode,
  output logic [3:0]      keycode,
  output logic            press,
  output logic            press_valid
);
  localparam int SW = $clog2(DWELL);
  logic [NCOL-1:0] sync1_q, sync2_q, hit;
  logic [SW-1:0] slot_q;
  logic [2:0] sel_q, tot;
  logic [1:0] acc_n_q, n;
  logic [3:0] acc_code_q, scan_q, row_code, code_d, candidate;
  logic sample, pass_done;
  always_comb begin
    hit       = ~sync2_q;
    n         = 2'(hit[0]) + 2'(hit[1]) + 2'(hit[2]);
    row_code  = hit[2] ? key_code(sel_q, 2'd2) : hit[1] ? key_code(sel_q, 2'd1) : key_code(sel_q, 2'd0);
    tot       = 3'(acc_n_q) + 3'(n);
    sample    = slot_q == SW'(DWELL - 1);
    pass_done = sample && sel_q == 3'(ROWS - 1);
    code_d    = (n != 2'd0) ? row_code : acc_code_q;
    candidate = (tot == 3'd1) ? code_d : KEY_NONE;
  end
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync1_q    <= '1;
      sync2_q    <= '1;
      slot_q     <= '0;
      sel_q      <= 3'd0;
      acc_n_q    <= 2'd0;
      acc_code_q <= KEY_NONE;
      scan_q     <= KEY_NONE;
    end else begin
      sync1_q <= column;
      sync2_q <= sync1_q;
      slot_q  <= sample ? '0 : slot_q + 1'b1;
      if (sample) begin
        sel_q <= pass_done ? 3'd0 : sel_q + 3'd1;
        // Contact count saturates at 2: anything above one is a chord.
        acc_n_q    <= pass_done ? 2'd0 : (tot >= 3'd2) ? 2'd2 : tot[1:0];
        acc_code_q <= pass_done ? KEY_NONE : code_d;
        if (pass_done) scan_q <= candidate;
      end
    end
  end
  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk_in      (clk_in),
    .reset       (reset),
    .pass_done   (pass_done),
    .candidate   (candidate),
    .keycode     (keycode),
    .press       (press),
    .press_valid (press_valid)
  );
  assign sel      = sel_q;
  assign scancode = scan_q;
endmodule
